// File: rtl/serial_argmax_framed.sv
// serial_argmax_framed
//   Framed serial argmax/argmin. Samples arrive one per accepted cycle and are
//   grouped into frames by in_last. At each frame end the index and value of
//   the extreme sample are registered and out_valid pulses for one cycle.
//
// Parameters
//   WIDTH        sample width
//   ARGMAX_WIDTH index width; a frame indexes up to 2**ARGMAX_WIDTH samples
//   SIGNED       1 = two's-complement compare, 0 = unsigned compare
//   TIE_LAST     0 = earliest index wins ties, 1 = latest index wins ties
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   in_valid   sample strobe
//   in_last    final sample of the frame (qualified by in_valid)
//   in         sample data
//   find_min   0 = argmax, 1 = argmin; latched with the first sample of a frame
//   out_valid  one-cycle pulse when the result registers are updated
//   argmax     index of the winner of the last completed frame
//   max_val    value of that winner
//   overflow   last completed frame had more than 2**ARGMAX_WIDTH samples
module serial_argmax_framed #(
    parameter int WIDTH        = 8,
    parameter int ARGMAX_WIDTH = 5,
    parameter int SIGNED       = 1,
    parameter int TIE_LAST     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [WIDTH-1:0]        in,
    input  logic                    find_min,
    output logic                    out_valid,
    output logic [ARGMAX_WIDTH-1:0] argmax,
    output logic [WIDTH-1:0]        max_val,
    output logic                    overflow
);

    // idx needs one extra bit so it can sit at 2**ARGMAX_WIDTH (saturated).
    localparam int IDXW = ARGMAX_WIDTH + 1;
    localparam logic [IDXW-1:0] IDX_LIMIT = {1'b1, {ARGMAX_WIDTH{1'b0}}};
    localparam logic [IDXW-1:0] IDX_ONE   = {{ARGMAX_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        S_FIRST = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t                  state_q,     state_d;
    logic [WIDTH-1:0]        best_q,      best_d;
    logic [ARGMAX_WIDTH-1:0] best_idx_q,  best_idx_d;
    logic [IDXW-1:0]         idx_q,       idx_d;
    logic                    ovf_q,       ovf_d;
    logic                    mode_q,      mode_d;
    logic                    out_valid_q, out_valid_d;
    logic [ARGMAX_WIDTH-1:0] argmax_q,    argmax_d;
    logic [WIDTH-1:0]        max_val_q,   max_val_d;
    logic                    overflow_q,  overflow_d;

    logic in_range;
    logic eq;
    logic gt;
    logic lt;
    logic better;

    assign in_range = (idx_q != IDX_LIMIT);
    assign eq       = (in == best_q);
    assign gt       = (SIGNED != 0) ? ($signed(in) > $signed(best_q)) : (in > best_q);
    assign lt       = (SIGNED != 0) ? ($signed(in) < $signed(best_q)) : (in < best_q);
    assign better   = eq ? (TIE_LAST != 0) : (mode_q ? lt : gt);

    always_comb begin
        state_d     = state_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        mode_d      = mode_q;
        out_valid_d = 1'b0;
        argmax_d    = argmax_q;
        max_val_d   = max_val_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_FIRST: begin
                if (in_valid) begin
                    best_d     = in;
                    best_idx_d = '0;
                    idx_d      = IDX_ONE;
                    ovf_d      = 1'b0;
                    mode_d     = find_min;
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        argmax_d    = '0;
                        max_val_d   = in;
                        overflow_d  = 1'b0;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    // Past the index range a sample still flags overflow
                    // but is never allowed to become the winner.
                    if (!in_range) begin
                        ovf_d = 1'b1;
                    end
                    if (better && in_range) begin
                        best_d     = in;
                        best_idx_d = idx_q[ARGMAX_WIDTH-1:0];
                    end
                    if (in_range) begin
                        idx_d = idx_q + IDX_ONE;
                    end
                    // Result includes the last sample, so load from _d.
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        argmax_d    = best_idx_d;
                        max_val_d   = best_d;
                        overflow_d  = ovf_d;
                        state_d     = S_FIRST;
                    end
                end
            end
            default: begin
                state_d = S_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_FIRST;
            best_q      <= '0;
            best_idx_q  <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            argmax_q    <= '0;
            max_val_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            argmax_q    <= argmax_d;
            max_val_q   <= max_val_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign argmax    = argmax_q;
    assign max_val   = max_val_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_argmax_framed.sv
// Testbench for serial_argmax_framed. Four instances with different parameter
// sets share one stimulus stream (4-bit instances see the low nibble). A
// frame-level reference model recomputes the expected winner of each frame
// directly from the list of samples.
module tb_serial_argmax_framed;

    // Config table: 0:W8/A5/signed/earliest 1:W4/A5/signed/latest
    //               2:W4/A2/unsigned/earliest 3:W8/A3/unsigned/latest
    localparam int CW [4] = '{8, 4, 4, 8};
    localparam int CA [4] = '{5, 5, 2, 3};
    localparam int CS [4] = '{1, 1, 0, 0};
    localparam int CT [4] = '{0, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic       lst;
    logic       fmin;
    logic [7:0] din;

    logic       a_ov, b_ov, c_ov, d_ov;
    logic [4:0] a_am, b_am;
    logic [1:0] c_am;
    logic [2:0] d_am;
    logic [7:0] a_mv, d_mv;
    logic [3:0] b_mv, c_mv;
    logic       a_of, b_of, c_of, d_of;

    logic        ov [4];
    logic [31:0] am [4];
    logic [31:0] mv [4];
    logic        of [4];

    // Reference model state
    logic [7:0]  frame [$];
    logic        fmode;
    logic        exp_ov;
    logic [31:0] h_am [4];
    logic [31:0] h_mv [4];
    logic        h_of [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_argmax_framed #(.WIDTH(8), .ARGMAX_WIDTH(5), .SIGNED(1), .TIE_LAST(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(vld), .in_last(lst), .in(din), .find_min(fmin),
        .out_valid(a_ov), .argmax(a_am), .max_val(a_mv), .overflow(a_of));
    serial_argmax_framed #(.WIDTH(4), .ARGMAX_WIDTH(5), .SIGNED(1), .TIE_LAST(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(vld), .in_last(lst), .in(din[3:0]), .find_min(fmin),
        .out_valid(b_ov), .argmax(b_am), .max_val(b_mv), .overflow(b_of));
    serial_argmax_framed #(.WIDTH(4), .ARGMAX_WIDTH(2), .SIGNED(0), .TIE_LAST(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(vld), .in_last(lst), .in(din[3:0]), .find_min(fmin),
        .out_valid(c_ov), .argmax(c_am), .max_val(c_mv), .overflow(c_of));
    serial_argmax_framed #(.WIDTH(8), .ARGMAX_WIDTH(3), .SIGNED(0), .TIE_LAST(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(vld), .in_last(lst), .in(din), .find_min(fmin),
        .out_valid(d_ov), .argmax(d_am), .max_val(d_mv), .overflow(d_of));

    always_comb begin
        ov[0] = a_ov; am[0] = 32'(a_am); mv[0] = 32'(a_mv); of[0] = a_of;
        ov[1] = b_ov; am[1] = 32'(b_am); mv[1] = 32'(b_mv); of[1] = b_of;
        ov[2] = c_ov; am[2] = 32'(c_am); mv[2] = 32'(c_mv); of[2] = c_of;
        ov[3] = d_ov; am[3] = 32'(d_am); mv[3] = 32'(d_mv); of[3] = d_of;
    end

    // Numeric key of a sample as seen by config c (masked, optionally signed).
    function automatic int keyv(input int c, input logic [7:0] x);
        int m;
        m = int'(x) & ((1 << CW[c]) - 1);
        if (CS[c] == 1 && m >= (1 << (CW[c] - 1))) m = m - (1 << CW[c]);
        return m;
    endfunction

    // Winner of a whole frame: scan the in-range samples, keep the extreme.
    function automatic void ref_eval(input int c, input logic [7:0] s [$], input logic mode,
                                     output logic [31:0] ri, output logic [31:0] rv,
                                     output logic ro);
        int lim, bk, k, mask;
        mask = (1 << CW[c]) - 1;
        lim  = 1 << CA[c];
        ro   = (s.size() > lim);
        ri   = 0;
        rv   = 32'(int'(s[0]) & mask);
        bk   = keyv(c, s[0]);
        for (int i = 1; i < s.size() && i < lim; i++) begin
            k = keyv(c, s[i]);
            if ((mode ? (k < bk) : (k > bk)) || (k == bk && CT[c] == 1)) begin
                bk = k;
                ri = 32'(i);
                rv = 32'(int'(s[i]) & mask);
            end
        end
    endfunction

    // Drive one cycle, then advance the reference model past that edge.
    task automatic step(input logic r, input logic v, input logic l,
                        input logic [7:0] d, input logic fm);
        rst = r; vld = v; lst = l; din = d; fmin = fm;
        @(posedge clk);
        #1;
        exp_ov = 1'b0;
        if (!r) begin
            frame.delete();
            for (int c = 0; c < 4; c++) begin
                h_am[c] = '0; h_mv[c] = '0; h_of[c] = 1'b0;
            end
        end else if (v) begin
            if (frame.size() == 0) fmode = fm;
            frame.push_back(d);
            if (l) begin
                for (int c = 0; c < 4; c++) ref_eval(c, frame, fmode, h_am[c], h_mv[c], h_of[c]);
                exp_ov = 1'b1;
                frame.delete();
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (ov[c] !== 1'b0 || am[c] !== 32'd0 || mv[c] !== 32'd0 || of[c] !== 1'b0) begin
                fails++;
                $display("FAIL reset cfg%0d: got v=%b idx=%0d val=%0d ovf=%b want all zero",
                         c, ov[c], am[c], mv[c], of[c]);
            end
        end
    endtask

    task automatic test_ramp();
        for (int v = -8; v <= 7; v++) begin
            step(1'b1, 1'b1, (v == 7), 8'(v), 1'b0);
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (ov[c] !== exp_ov || am[c] !== h_am[c] || mv[c] !== h_mv[c] || of[c] !== h_of[c]) begin
                    fails++;
                    $display("FAIL ramp cfg%0d: got v=%b idx=%0d val=%0d ovf=%b want v=%b idx=%0d val=%0d ovf=%b",
                             c, ov[c], am[c], mv[c], of[c], exp_ov, h_am[c], h_mv[c], h_of[c]);
                end
            end
        end
        tests++;
        if (b_ov !== 1'b1 || b_am !== 5'd15 || b_mv !== 4'd7 || b_of !== 1'b0) begin
            fails++;
            $display("FAIL ramp_const: got v=%b idx=%0d val=%0d ovf=%b want v=1 idx=15 val=7 ovf=0",
                     b_ov, b_am, b_mv, b_of);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tests++;
        if (b_ov !== 1'b0 || b_am !== 5'd15 || b_mv !== 4'd7) begin
            fails++;
            $display("FAIL ramp_hold: got v=%b idx=%0d val=%0d want v=0 idx=15 val=7", b_ov, b_am, b_mv);
        end
    endtask

    task automatic test_ties();
        logic [7:0] d [4];
        d = '{8'd3, 8'd5, 8'd5, 8'd2};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 3), d[i], 1'b0);
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (ov[c] !== exp_ov || am[c] !== h_am[c] || mv[c] !== h_mv[c] || of[c] !== h_of[c]) begin
                    fails++;
                    $display("FAIL ties cfg%0d: got v=%b idx=%0d val=%0d ovf=%b want v=%b idx=%0d val=%0d ovf=%b",
                             c, ov[c], am[c], mv[c], of[c], exp_ov, h_am[c], h_mv[c], h_of[c]);
                end
            end
        end
        tests++;
        if (a_am !== 5'd1 || a_mv !== 8'd5 || b_am !== 5'd2 || b_mv !== 4'd5) begin
            fails++;
            $display("FAIL ties_const: got early=%0d/%0d late=%0d/%0d want early=1/5 late=2/5",
                     a_am, a_mv, b_am, b_mv);
        end
    endtask

    task automatic test_argmin();
        logic [7:0] d [4];
        d = '{8'd4, 8'hFD, 8'd6, 8'hFD};
        for (int i = 0; i < 4; i++) begin
            // find_min only matters on the first sample; toggled afterwards.
            step(1'b1, 1'b1, (i == 3), d[i], (i == 0));
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (ov[c] !== exp_ov || am[c] !== h_am[c] || mv[c] !== h_mv[c] || of[c] !== h_of[c]) begin
                    fails++;
                    $display("FAIL argmin cfg%0d: got v=%b idx=%0d val=%0d ovf=%b want v=%b idx=%0d val=%0d ovf=%b",
                             c, ov[c], am[c], mv[c], of[c], exp_ov, h_am[c], h_mv[c], h_of[c]);
                end
            end
        end
        tests++;
        if (a_am !== 5'd1 || a_mv !== 8'hFD || c_am !== 2'd0 || c_mv !== 4'd4) begin
            fails++;
            $display("FAIL argmin_const: got signed=%0d/%0d unsigned=%0d/%0d want signed=1/253 unsigned=0/4",
                     a_am, a_mv, c_am, c_mv);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        logic [3:0] l;
        logic [7:0] d [4];
        int pulses;
        v = 4'b1101; l = 4'b1100; d = '{8'd1, 8'd0, 8'd2, 8'd5};
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, v[i], l[i], d[i], 1'b0);
            if (a_ov === 1'b1) pulses++;
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (ov[c] !== exp_ov || am[c] !== h_am[c] || mv[c] !== h_mv[c] || of[c] !== h_of[c]) begin
                    fails++;
                    $display("FAIL b2b cfg%0d: got v=%b idx=%0d val=%0d ovf=%b want v=%b idx=%0d val=%0d ovf=%b",
                             c, ov[c], am[c], mv[c], of[c], exp_ov, h_am[c], h_mv[c], h_of[c]);
                end
            end
            if (i == 2) begin
                tests++;
                if (a_ov !== 1'b1 || a_am !== 5'd1 || a_mv !== 8'd2) begin
                    fails++;
                    $display("FAIL b2b_first: got v=%b idx=%0d val=%0d want v=1 idx=1 val=2", a_ov, a_am, a_mv);
                end
            end
        end
        tests++;
        if (pulses != 2 || a_am !== 5'd0 || a_mv !== 8'd5) begin
            fails++;
            $display("FAIL b2b_second: got pulses=%0d idx=%0d val=%0d want pulses=2 idx=0 val=5",
                     pulses, a_am, a_mv);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d [8];
        logic [7:0] l;
        d = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd9, 8'd7, 8'd1, 8'd2};
        l = 8'b1010_0000;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, l[i], d[i], 1'b0);
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (ov[c] !== exp_ov || am[c] !== h_am[c] || mv[c] !== h_mv[c] || of[c] !== h_of[c]) begin
                    fails++;
                    $display("FAIL ovf cfg%0d: got v=%b idx=%0d val=%0d ovf=%b want v=%b idx=%0d val=%0d ovf=%b",
                             c, ov[c], am[c], mv[c], of[c], exp_ov, h_am[c], h_mv[c], h_of[c]);
                end
            end
            if (i == 5) begin
                tests++;
                if (c_ov !== 1'b1 || c_of !== 1'b1 || c_am !== 2'd3 || c_mv !== 4'd3) begin
                    fails++;
                    $display("FAIL ovf_const: got v=%b ovf=%b idx=%0d val=%0d want v=1 ovf=1 idx=3 val=3",
                             c_ov, c_of, c_am, c_mv);
                end
            end
        end
        tests++;
        if (c_of !== 1'b0 || c_am !== 2'd1 || c_mv !== 4'd2) begin
            fails++;
            $display("FAIL ovf_clear: got ovf=%b idx=%0d val=%0d want ovf=0 idx=1 val=2", c_of, c_am, c_mv);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] r, v, l;
        logic [7:0] d [5];
        int pulses;
        r = 5'b11011; v = 5'b11011; l = 5'b10000;
        d = '{8'd9, 8'd9, 8'd0, 8'd0, 8'd1};
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(r[i], v[i], l[i], d[i], 1'b0);
            if (a_ov === 1'b1) pulses++;
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (ov[c] !== exp_ov || am[c] !== h_am[c] || mv[c] !== h_mv[c] || of[c] !== h_of[c]) begin
                    fails++;
                    $display("FAIL rstmid cfg%0d: got v=%b idx=%0d val=%0d ovf=%b want v=%b idx=%0d val=%0d ovf=%b",
                             c, ov[c], am[c], mv[c], of[c], exp_ov, h_am[c], h_mv[c], h_of[c]);
                end
            end
        end
        tests++;
        if (pulses != 1 || a_am !== 5'd1 || a_mv !== 8'd1) begin
            fails++;
            $display("FAIL rstmid_const: got pulses=%0d idx=%0d val=%0d want pulses=1 idx=1 val=1",
                     pulses, a_am, a_mv);
        end
    endtask

    task automatic test_random();
        int len;
        int sent;
        logic fm;
        for (int f = 0; f < 60; f++) begin
            len  = $urandom_range(1, 36);
            sent = 0;
            while (sent < len) begin
                fm = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 7) begin
                    sent++;
                    step(1'b1, 1'b1, (sent == len), 8'($urandom_range(0, 255)), fm);
                end else begin
                    step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), fm);
                end
                for (int c = 0; c < 4; c++) begin
                    tests++;
                    if (ov[c] !== exp_ov || am[c] !== h_am[c] || mv[c] !== h_mv[c] || of[c] !== h_of[c]) begin
                        fails++;
                        $display("FAIL random f%0d cfg%0d: got v=%b idx=%0d val=%0d ovf=%b want v=%b idx=%0d val=%0d ovf=%b",
                                 f, c, ov[c], am[c], mv[c], of[c], exp_ov, h_am[c], h_mv[c], h_of[c]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; vld = 1'b0; lst = 1'b0; din = '0; fmin = 1'b0;
        fmode = 1'b0; exp_ov = 1'b0;
        for (int c = 0; c < 4; c++) begin
            h_am[c] = '0; h_mv[c] = '0; h_of[c] = 1'b0;
        end
        test_reset();
        test_ramp();
        test_ties();
        test_argmin();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
